cla_add_arbiter: RTL and testbench
==================================

Name: cla_add_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered 16-bit carry-lookahead adder (CLA_16_4) among NREQ requesters. It accepts operand pairs through valid/ready handshakes and issues at most one operation per clock to the adder. Each result is returned with the requester's ID, aligned to the adder's pipeline latency. It sits between the requesting datapath blocks and a single CLA_16_4 instance, and shares that instance's clock and reset nets.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand/sum width; must equal adder width
LAT, 1, adder latency in clocks from add_a/add_b to add_sum/add_cout (CLA_16_4 = 1)
IDW, $clog2(NREQ), width of rsp_id

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset; same net as the adder's reset
req_valid  in  NREQ  per-requester request valid
req_a  in  NREQ*W  operand A, requester i at bits [i*W +: W]
req_b  in  NREQ*W  operand B, same packing
req_ready  out  NREQ  one-hot grant; at most one bit set per cycle
add_a  out  W  operand A to adder, registered
add_b  out  W  operand B to adder, registered
add_sum  in  W  adder Sum
add_cout  in  1  adder Cout
rsp_valid  out  1  one-cycle pulse per completed add
rsp_id  out  IDW  requester index of the result
rsp_sum  out  W  add_sum passthrough, valid when rsp_valid=1
rsp_cout  out  1  add_cout passthrough, valid when rsp_valid=1
inflight  out  $clog2(LAT+2)  count of accepted ops not yet responded

Behaviour:
- Reset, synchronous with clock high and reset=1:
  - ptr=0, add_a=0, add_b=0.
  - Tag pipeline valid bits cleared, so rsp_valid=0, rsp_id=0 and inflight=0.
  - req_ready=0 while reset=1.
- Arbitration (combinational):
  - Winner is the first i with req_valid[i]=1, scanning from ptr upward with wrap modulo NREQ.
  - req_ready[winner]=1; all other bits are 0.
  - req_ready may depend on req_valid.
  - No valid requests: req_ready=0.
- Transfer: occurs when req_valid[i] && req_ready[i]. Requesters must hold their data stable until transferred.
- Pointer update:
  - After a transfer from requester i, ptr <= (i+1) mod NREQ.
  - No transfer: ptr holds.
  - Fairness: a continuously-valid requester waits at most NREQ-1 cycles.
- Issue stage (cycle N = transfer cycle):
  - At posedge ending cycle N: add_a <= req_a[i], add_b <= req_b[i].
  - The tag pipeline stage 0 captures {valid=1, id=i}.
  - No transfer: add_a/add_b <= 0 and stage 0 valid <= 0.
- Tag pipeline:
  - LAT registered stages follow the issue stage.
  - Stage LAT drives rsp_valid and rsp_id.
- Response timing:
  - rsp_valid=1 in cycle N+1+LAT, which is N+2 for LAT=1.
  - In that cycle rsp_sum=add_sum, rsp_cout=add_cout and rsp_id=i.
- Throughput and ordering:
  - One op per cycle is sustained; back-to-back transfers yield back-to-back rsp_valid pulses.
  - Results return in issue order.
  - There is no response backpressure; consumers must accept every rsp_valid.
- Arithmetic: {rsp_cout, rsp_sum} = req_a + req_b, computed as (W+1)-bit unsigned. Overflow shows only in rsp_cout.
- inflight:
  - Increments on a transfer and decrements on rsp_valid.
  - Simultaneous transfer and rsp_valid: no change.
  - Range 0..LAT+1.
- Reset mid-operation: all in-flight ops are dropped. No rsp_valid is produced for them in the cycles after reset deasserts.
- Simultaneous requests: all other valid requesters stall; exactly one is served per cycle.
- Idle: rsp_sum and rsp_cout are don't-care when rsp_valid=0. The bench must check them only on rsp_valid.

Test Plan:
1. Single requester 0: a=00FF, b=FF01, transfer at cycle N.
   -> rsp_valid=1 only at N+2 with rsp_id=0, sum=0000, cout=1; inflight goes 1,1,0.
2. All 4 valid continuously, ptr=0, after reset:
   - requester i issues a=80FF+i, b=8080.
   - -> grants go 0,1,2,3,0; requester 0 gets sum=017F cout=1, requester 1 gets 0180.
   - -> rsp_ids return 0,1,2,3 in consecutive cycles.
3. Requesters 1 and 3 valid, ptr=2.
   - -> 3 is granted first, then ptr=0 and 1 is granted.
   - -> responses: 00FF+FF80 gives 007F cout=1 (id 3), then 1111+2222 gives 3333 cout=0 (id 1).
4. Back-to-back transfers from requester 2 over 5 cycles with b=0001, a=FFFF,0000,7FFF,8000,1234.
   -> 5 consecutive rsp_valid pulses with sums 0000/c1, 0001, 8000, 8001, 1235 (cout=0 except the first).
5. Reset asserted for 1 cycle, one cycle after a transfer.
   -> no rsp_valid for that op, inflight=0, next grant goes to requester 0 with ptr=0.
6. No req_valid for 10 cycles.
   -> req_ready=0, add_a=add_b=0, rsp_valid=0, ptr unchanged.

Source files
------------

// File: rtl/cla_add_arbiter.sv
// rtl/cla_add_arbiter.sv - round-robin sharing of one registered CLA adder among NREQ requesters
// Results come back tagged with the requester index, aligned to the adder latency.
module cla_add_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 16,
    parameter int LAT  = 1,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*W-1:0]        i_req_a,
    input  logic [NREQ*W-1:0]        i_req_b,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [W-1:0]             o_add_a,
    output logic [W-1:0]             o_add_b,
    input  logic [W-1:0]             i_add_sum,
    input  logic                     i_add_cout,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic [W-1:0]             o_rsp_sum,
    output logic                     o_rsp_cout,
    output logic [$clog2(LAT+2)-1:0] o_inflight
);

    localparam int CW = $clog2(LAT + 2);

    logic [IDW-1:0] r_ptr;
    logic [W-1:0]   r_add_a;
    logic [W-1:0]   r_add_b;
    logic [LAT:0]   r_tag_v;
    logic [IDW-1:0] r_tag_id [0:LAT];
    logic [CW-1:0]  r_inflight;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic            w_xfer;
    logic [IDW-1:0]  w_ptr_nxt;

    // Scan from the pointer upward with wrap; first valid requester wins.
    always_comb begin
        logic [IDW-1:0] v_idx;
        w_grant = '0;
        w_win   = '0;
        w_found = 1'b0;
        v_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            v_idx = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && i_req_valid[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
        if (w_found && !i_reset) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign w_xfer    = w_found && !i_reset;
    assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + IDW'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_add_a    <= '0;
            r_add_b    <= '0;
            r_tag_v    <= '0;
            r_inflight <= '0;
            for (int s = 0; s <= LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            if (w_xfer) begin
                r_ptr   <= w_ptr_nxt;
                r_add_a <= i_req_a[int'(w_win)*W +: W];
                r_add_b <= i_req_b[int'(w_win)*W +: W];
            end else begin
                r_add_a <= '0;
                r_add_b <= '0;
            end
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_win;
            for (int s = 1; s <= LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
            // A transfer and a response in the same cycle cancel out.
            if (w_xfer && !r_tag_v[LAT]) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_xfer && r_tag_v[LAT]) begin
                r_inflight <= r_inflight - CW'(1);
            end
        end
    end

    assign o_req_ready = w_grant;
    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_rsp_valid = r_tag_v[LAT];
    assign o_rsp_id    = r_tag_id[LAT];
    assign o_rsp_sum   = i_add_sum;
    assign o_rsp_cout  = i_add_cout;
    assign o_inflight  = r_inflight;

endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb/tb_cla_add_arbiter.sv - self-checking bench for cla_add_arbiter with a registered adder model
module tb_cla_add_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [1:0]        inflight;

    always #5 clk = ~clk;

    cla_add_arbiter #(.NREQ(NREQ), .W(W), .LAT(1)) dut (
        .i_clock(clk), .i_reset(reset),
        .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
        .o_req_ready(req_ready), .o_add_a(add_a), .o_add_b(add_b),
        .i_add_sum(add_sum), .i_add_cout(add_cout),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id),
        .o_rsp_sum(rsp_sum), .o_rsp_cout(rsp_cout), .o_inflight(inflight)
    );

    // Stand-in for the one-cycle registered CLA_16_4
    always_ff @(posedge clk) begin
        if (reset) {add_cout, add_sum} <= '0;
        else       {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
    end

    typedef struct { int id; logic [16:0] res; int due; } exp_t;
    typedef struct { int id; logic [15:0] sum; logic cout; int cyc; } rsp_t;
    typedef struct { int id; logic [15:0] a; logic [15:0] b; logic [15:0] sum; logic cout; } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int m_ptr = 0;
    logic [15:0] m_add_a = '0;
    logic [15:0] m_add_b = '0;
    exp_t mq[$];
    rsp_t obs[$];
    int grants[$];
    int g_this;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        logic exp_rv;
        int w;
        int seen;
        @(negedge clk);
        exp_ready = '0;
        w = -1;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_rv = (mq.size() > 0) && (mq[0].due == cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv && rsp_valid === 1'b1) begin
            chk("rsp_id", 32'(rsp_id), 32'(mq[0].id));
            chk("rsp_sum", 32'(rsp_sum), 32'(mq[0].res[15:0]));
            chk("rsp_cout", 32'(rsp_cout), 32'(mq[0].res[16]));
        end
        if (rsp_valid === 1'b1) obs.push_back('{int'(rsp_id), rsp_sum, rsp_cout, cyc});
        chk("inflight", 32'(inflight), 32'(mq.size()));
        chk("add_a", 32'(add_a), 32'(m_add_a));
        chk("add_b", 32'(add_b), 32'(m_add_b));
        seen = -1;
        for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k] === 1'b1) seen = k;
        if (seen >= 0) grants.push_back(seen);
        if (exp_rv) void'(mq.pop_front());
        g_this = w;
        if (reset) begin
            mq.delete();
            m_ptr = 0;
            m_add_a = '0;
            m_add_b = '0;
        end else if (w >= 0) begin
            m_add_a = req_a[w*W +: W];
            m_add_b = req_b[w*W +: W];
            mq.push_back('{w, {1'b0, m_add_a} + {1'b0, m_add_b}, cyc + 2});
            m_ptr = (w + 1) % NREQ;
        end else begin
            m_add_a = '0;
            m_add_b = '0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic clear_obs();
        obs.delete();
        grants.delete();
    endtask

    task automatic chk_obs(input string nm, input int k, input int id, input logic [15:0] sum, input logic cout);
        if (k < obs.size()) begin
            chk({nm, "_id"}, 32'(obs[k].id), 32'(id));
            chk({nm, "_sum"}, 32'(obs[k].sum), 32'(sum));
            chk({nm, "_cout"}, 32'(obs[k].cout), 32'(cout));
            chk({nm, "_cyc"}, 32'(obs[k].cyc), 32'(obs[0].cyc + k));
        end
    endtask

    vec_t tbl[7];
    logic [NREQ-1:0] pend_v;
    logic [15:0] pa[NREQ];
    logic [15:0] pb[NREQ];

    initial begin
        tbl[0] = '{0, 16'h00FF, 16'hFF01, 16'h0000, 1'b1};
        tbl[1] = '{2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[2] = '{1, 16'h1111, 16'h2222, 16'h3333, 1'b0};
        tbl[3] = '{3, 16'h00FF, 16'hFF80, 16'h007F, 1'b1};
        tbl[4] = '{2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0};
        tbl[5] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tbl[6] = '{0, 16'h0000, 16'h0000, 16'h0000, 1'b0};

        reset = 1'b1;
        req_valid = '1;
        req_a = '0;
        req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_add_a", 32'(add_a), 32'h0);
        chk("rst_add_b", 32'(add_b), 32'h0);
        reset = 1'b0;
        req_valid = '0;

        // Single-requester vectors with constant expectations
        for (int t = 0; t < 7; t++) begin
            clear_obs();
            set_req(tbl[t].id, tbl[t].a, tbl[t].b);
            req_valid = '0;
            req_valid[tbl[t].id] = 1'b1;
            cycle();
            idle(2);
            chk("tbl_count", 32'(obs.size()), 32'd1);
            chk_obs("tbl", 0, tbl[t].id, tbl[t].sum, tbl[t].cout);
        end

        // All four valid from ptr=0
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        clear_obs();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'h80FF + 16'(i), 16'h8080);
        req_valid = '1;
        repeat (5) cycle();
        idle(3);
        chk("rr_grants", 32'(grants.size()), 32'd5);
        for (int k = 0; k < 5; k++) if (k < grants.size()) chk("rr_grant", 32'(grants[k]), 32'(k % NREQ));
        chk("rr_count", 32'(obs.size()), 32'd5);
        chk_obs("rr0", 0, 0, 16'h017F, 1'b1);
        chk_obs("rr1", 1, 1, 16'h0180, 1'b1);
        chk_obs("rr2", 2, 2, 16'h0181, 1'b1);
        chk_obs("rr3", 3, 3, 16'h0182, 1'b1);

        // ptr=2 with requesters 1 and 3 valid
        set_req(1, 16'h1111, 16'h2222);
        req_valid = 4'b0010;
        cycle();
        idle(2);
        clear_obs();
        set_req(3, 16'h00FF, 16'hFF80);
        req_valid = 4'b1010;
        cycle();
        req_valid = 4'b0010;
        cycle();
        idle(3);
        chk("wrap_grants", 32'(grants.size()), 32'd2);
        if (grants.size() == 2) begin
            chk("wrap_g0", 32'(grants[0]), 32'd3);
            chk("wrap_g1", 32'(grants[1]), 32'd1);
        end
        chk("wrap_count", 32'(obs.size()), 32'd2);
        chk_obs("wrap0", 0, 3, 16'h007F, 1'b1);
        chk_obs("wrap1", 1, 1, 16'h3333, 1'b0);

        // Back-to-back from requester 2
        clear_obs();
        req_valid = 4'b0100;
        begin
            logic [15:0] seq [5];
            seq = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h1234};
            for (int k = 0; k < 5; k++) begin
                set_req(2, seq[k], 16'h0001);
                cycle();
            end
        end
        idle(3);
        chk("b2b_count", 32'(obs.size()), 32'd5);
        chk_obs("b2b0", 0, 2, 16'h0000, 1'b1);
        chk_obs("b2b1", 1, 2, 16'h0001, 1'b0);
        chk_obs("b2b2", 2, 2, 16'h8000, 1'b0);
        chk_obs("b2b3", 3, 2, 16'h8001, 1'b0);
        chk_obs("b2b4", 4, 2, 16'h1235, 1'b0);

        // Reset one cycle after a transfer drops the op and restarts at ptr=0
        set_req(2, 16'h0001, 16'h0002);
        for (int i = 0; i < NREQ; i++) if (i != 2) set_req(i, 16'h0010, 16'h0020);
        req_valid = 4'b0100;
        cycle();
        req_valid = '1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_mid_inflight", 32'(inflight), 32'h0);
        clear_obs();
        cycle();
        idle(3);
        chk("rst_mid_grants", 32'(grants.size()), 32'd1);
        if (grants.size() == 1) chk("rst_mid_g0", 32'(grants[0]), 32'd0);
        chk("rst_mid_count", 32'(obs.size()), 32'd1);
        chk_obs("rst_mid", 0, 0, 16'h0030, 1'b0);

        // Idle stretch keeps the pointer
        clear_obs();
        idle(10);
        chk("idle_count", 32'(obs.size()), 32'd0);
        req_valid = '1;
        cycle();
        idle(3);
        if (grants.size() > 0) chk("idle_ptr", 32'(grants[0]), 32'd1);
        else chk("idle_grants", 32'(grants.size()), 32'd1);

        // Random traffic; requesters hold operands until transferred
        pend_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = '0;
            pb[i] = '0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_v[i] && $urandom_range(0, 9) < 4) begin
                    pend_v[i] = 1'b1;
                    pa[i] = 16'($urandom);
                    pb[i] = 16'($urandom);
                end
                set_req(i, pa[i], pb[i]);
            end
            req_valid = pend_v;
            reset = ($urandom_range(0, 63) == 0);
            cycle();
            if (g_this >= 0) pend_v[g_this] = 1'b0;
        end
        reset = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
